// File: rtl/edge_scan_lr.sv
// edge_scan_lr: scans rows top..bottom outward from a seed column through one frame-buffer read port
// and reports the shape's horizontal extent with a done pulse.
module edge_scan_lr #(
    parameter int X_SZ      = 8,
    parameter int Y_SZ      = 7,
    parameter int ADDR_SZ   = 15,
    parameter int COL_SZ    = 3,
    parameter int X_RES     = 160,
    parameter int THRESHOLD = 0,
    parameter int BG_MATCH  = 1,
    parameter int RD_LAT    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [Y_SZ-1:0]    most_top,
    input  logic [Y_SZ-1:0]    most_bottom,
    input  logic [X_SZ-1:0]    mid_pix,
    output logic [ADDR_SZ-1:0] mem_addr,
    output logic               mem_rd,
    input  logic [COL_SZ-1:0]  mem_data,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [X_SZ-1:0]    most_left,
    output logic [X_SZ-1:0]    most_right
);
    localparam int W   = ADDR_SZ + X_SZ;
    localparam int XW1 = X_SZ + 1;
    localparam logic [X_SZ-1:0]   X_LAST = X_SZ'(X_RES - 1);
    localparam logic [X_SZ:0]     X_LIM  = XW1'(X_RES);
    localparam logic [X_SZ-1:0]   X_ONE  = X_SZ'(1);
    localparam logic [Y_SZ-1:0]   Y_ONE  = Y_SZ'(1);
    localparam logic [COL_SZ-1:0] THR    = COL_SZ'(THRESHOLD);
    localparam logic [2:0]        LAT    = 3'(RD_LAT);

    typedef enum logic [3:0] {
        IDLE, CHECK, ROW_INIT, R_REQ, R_WAIT, L_INIT, L_REQ, L_WAIT, NEXT_ROW, DONE
    } state_t;

    state_t              state_q, state_d;
    logic [Y_SZ-1:0]     top_q, top_d, bot_q, bot_d, y_q, y_d;
    logic [X_SZ-1:0]     mid_q, mid_d, x_q, x_d, left_q, left_d, right_q, right_d, xt;
    logic [2:0]          cnt_q, cnt_d;
    logic                busy_q, busy_d, done_q, done_d, err_q, err_d, rd_q, rd_d;
    logic [ADDR_SZ-1:0]  addr_q, addr_d;
    logic [W-1:0]        addr_w;
    logic                bg, sample, bad;

    always_comb begin
        state_d = state_q;
        top_d   = top_q;
        bot_d   = bot_q;
        mid_d   = mid_q;
        y_d     = y_q;
        x_d     = x_q;
        left_d  = left_q;
        right_d = right_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        err_d   = err_q;
        bad     = 1'b0;
        bg      = (BG_MATCH != 0) ? (mem_data == THR) : (mem_data != THR);
        sample  = cnt_q == LAT;
        case (state_q)
            IDLE: if (start) begin
                top_d   = most_top;
                bot_d   = most_bottom;
                mid_d   = mid_pix;
                left_d  = mid_pix;
                right_d = mid_pix;
                y_d     = most_top;
                err_d   = 1'b0;
                busy_d  = 1'b1;
                state_d = CHECK;
            end
            CHECK: begin
                bad     = top_q > bot_q || {1'b0, mid_q} >= X_LIM;
                err_d   = bad;
                state_d = bad ? DONE : ROW_INIT;
            end
            ROW_INIT: begin
                x_d     = mid_q;
                state_d = mid_q == X_LAST ? L_INIT : R_REQ;
            end
            R_REQ: begin
                cnt_d   = 3'd1;
                state_d = R_WAIT;
            end
            R_WAIT: if (!sample) cnt_d = cnt_q + 3'd1;
            else if (bg) state_d = L_INIT;
            else begin
                x_d     = x_q + X_ONE;
                right_d = x_d > right_q ? x_d : right_q;
                state_d = x_d == X_LAST ? L_INIT : R_REQ;
            end
            L_INIT: begin
                x_d     = mid_q;
                state_d = mid_q == '0 ? NEXT_ROW : L_REQ;
            end
            L_REQ: begin
                cnt_d   = 3'd1;
                state_d = L_WAIT;
            end
            L_WAIT: if (!sample) cnt_d = cnt_q + 3'd1;
            else if (bg) state_d = NEXT_ROW;
            else begin
                x_d     = x_q - X_ONE;
                left_d  = x_d < left_q ? x_d : left_q;
                state_d = x_d == '0 ? NEXT_ROW : L_REQ;
            end
            // a row spanning the whole image cannot widen further, so stop early
            NEXT_ROW: if (y_q == bot_q || (left_q == '0 && right_q == X_LAST)) state_d = DONE;
            else begin
                y_d     = y_q + Y_ONE;
                state_d = ROW_INIT;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        done_d = state_d == DONE;
        rd_d   = state_d == R_REQ || state_d == L_REQ;
        xt     = state_d == R_REQ ? x_d + X_ONE : x_d - X_ONE;
        addr_w = W'(y_d) * W'(X_RES) + W'(xt);
        addr_d = rd_d ? addr_w[ADDR_SZ-1:0] : addr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            top_q   <= '0;
            bot_q   <= '0;
            mid_q   <= '0;
            y_q     <= '0;
            x_q     <= '0;
            left_q  <= '0;
            right_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            top_q   <= top_d;
            bot_q   <= bot_d;
            mid_q   <= mid_d;
            y_q     <= y_d;
            x_q     <= x_d;
            left_q  <= left_d;
            right_q <= right_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
        end
    end

    assign mem_addr   = addr_q;
    assign mem_rd     = rd_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign most_left  = left_q;
    assign most_right = right_q;
endmodule
